// File: rtl/ram_scan_pkg.sv
// Shared definitions for the RAM snapshot scanner: FSM encoding and default widths.
package ram_scan_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 32;
  localparam int DEFAULT_ADDRESS_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } scan_state_t;

endpackage

// File: rtl/ram_scan_ctrl.sv
// Shares a single-port RAM between the processor and a frame scanner that
// copies SCAN_COUNT consecutive words into a snapshot stream once per frame_start.
module ram_scan_ctrl
  import ram_scan_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int SCAN_BASE     = 1,
  parameter int SCAN_COUNT    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_en,
  input  logic                     cpu_wEn,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_dataIn,
  output logic                     ram_wEn,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_dataIn,
  input  logic [DATA_WIDTH-1:0]    ram_dataOut,
  input  logic                     frame_start,
  output logic                     snap_wr_en,
  output logic [7:0]               snap_idx,
  output logic [DATA_WIDTH-1:0]    snap_data,
  output logic                     scan_busy,
  output logic                     scan_done,
  output logic                     overrun,
  input  logic                     overrun_clr
);

  localparam logic [7:0]               LAST_IDX  = 8'(SCAN_COUNT - 1);
  localparam logic [ADDRESS_WIDTH-1:0] BASE_ADDR = ADDRESS_WIDTH'(SCAN_BASE);

  // Handshake: snap_wr_en is a pure valid strobe (no ready); each high cycle
  // carries exactly one word {snap_idx, snap_data}. scan_done follows the
  // cycle after the final word. The consumer cannot stall the scanner.

  scan_state_t state, state_nxt;
  logic [7:0]  issue_idx, issue_idx_nxt;
  logic        issue;
  logic        pend;
  logic [7:0]  pend_idx;
  logic        overrun_set;

  always_comb begin
    state_nxt     = state;
    issue_idx_nxt = issue_idx;
    issue         = 1'b0;
    case (state)
      IDLE: begin
        // A request landing on the scan_done cycle is an overrun, not a restart.
        if (frame_start && !scan_done) begin
          state_nxt     = SCAN;
          issue_idx_nxt = 8'd0;
        end
      end
      SCAN: begin
        if (!cpu_en) begin
          issue         = 1'b1;
          issue_idx_nxt = issue_idx + 8'd1;
          if (issue_idx == LAST_IDX) state_nxt = DRAIN;
        end
      end
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Processor always wins the port; the scanner only reads.
  always_comb begin
    ram_wEn    = 1'b0;
    ram_addr   = cpu_addr;
    ram_dataIn = cpu_dataIn;
    if (cpu_en) begin
      ram_wEn = cpu_wEn;
    end else if (issue) begin
      ram_addr = BASE_ADDR + ADDRESS_WIDTH'(issue_idx);
    end
  end

  assign scan_busy   = (state != IDLE);
  assign overrun_set = frame_start && ((state != IDLE) || scan_done);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      issue_idx  <= 8'd0;
      pend       <= 1'b0;
      pend_idx   <= 8'd0;
      snap_wr_en <= 1'b0;
      snap_idx   <= 8'd0;
      snap_data  <= '0;
      scan_done  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state     <= state_nxt;
      issue_idx <= issue_idx_nxt;
      pend      <= issue;
      pend_idx  <= issue_idx;
      // RAM output reflects the read issued last cycle, whatever cpu_en is now.
      snap_wr_en <= pend;
      if (pend) begin
        snap_idx  <= pend_idx;
        snap_data <= ram_dataOut;
      end
      scan_done <= snap_wr_en && (snap_idx == LAST_IDX);
      if (overrun_set)      overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_scan_ctrl.sv
// Directed bench for ram_scan_ctrl: behavioural RAM behind the port, expected
// snapshot words queued by the stimulus and popped by a monitor.
module tb_ram_scan_ctrl;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam logic [AW-1:0] PARK = 12'hFFF;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_en, cpu_wEn;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_dataIn;
  logic          ram_wEn;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dataIn;
  logic [DW-1:0] ram_dataOut;
  logic          frame_start, overrun_clr;
  logic          snap_wr_en, scan_busy, scan_done, overrun;
  logic [7:0]    snap_idx;
  logic [DW-1:0] snap_data;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [39:0]   exp_q [$];
  logic [DW-1:0] img [8];
  int checks = 0;
  int failures = 0;
  int snaps_seen = 0;
  int zero_hits = 0;
  bit done_due = 0;

  ram_scan_ctrl #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .SCAN_BASE(1), .SCAN_COUNT(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_en(cpu_en), .cpu_wEn(cpu_wEn), .cpu_addr(cpu_addr), .cpu_dataIn(cpu_dataIn),
    .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut),
    .frame_start(frame_start),
    .snap_wr_en(snap_wr_en), .snap_idx(snap_idx), .snap_data(snap_data),
    .scan_busy(scan_busy), .scan_done(scan_done),
    .overrun(overrun), .overrun_clr(overrun_clr)
  );

  // clock / RAM model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wEn) mem[ram_addr] <= ram_dataIn;
    ram_dataOut <= mem[ram_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // scoreboard monitor
  task automatic monitor();
    logic [39:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (!cpu_en && ram_addr == '0) zero_hits++;
        if (done_due) begin
          check("scan_done_pulse", {63'd0, scan_done}, 64'd1);
          done_due = 0;
        end else if (scan_done) begin
          check("scan_done_unexpected", 64'd1, 64'd0);
        end
        if (snap_wr_en) begin
          if (exp_q.size() == 0) begin
            check("snap_unexpected", {56'd0, snap_idx}, 64'hFF);
          end else begin
            e = exp_q.pop_front();
            check("snap_word", {24'd0, snap_idx, snap_data}, {24'd0, e});
            snaps_seen++;
            if (e[39:32] == 8'd7) done_due = 1;
          end
        end
      end
    end
  endtask

  // driver tasks
  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk); #1;
    cpu_en = 1'b1; cpu_wEn = 1'b1; cpu_addr = a; cpu_dataIn = d;
    @(posedge clk); #1;
    cpu_en = 1'b0; cpu_wEn = 1'b0; cpu_addr = PARK;
  endtask

  task automatic push_img();
    for (int i = 0; i < 8; i++) exp_q.push_back({8'(i), img[i]});
  endtask

  task automatic set_img(input logic [DW-1:0] w0, input logic [DW-1:0] w4);
    for (int i = 0; i < 8; i++) img[i] = DW'((i + 1) * 32'h11);
    img[0] = w0;
    img[4] = w4;
  endtask

  // kind: 1 two-cycle cpu stall writing addr5, 2 cpu write addr1, 3 frame_start,
  //       4 cpu write addr0 (new-game flag), 5 frame_start with overrun_clr
  task automatic run_scan(input string name, input int inj_at, input int kind, input int exp_cycles);
    int cycles;
    bit got;
    cycles = 0;
    got = 0;
    push_img();
    @(posedge clk); #1 frame_start = 1'b1;
    fork
      begin
        @(posedge clk); #1 frame_start = 1'b0;
      end
      begin
        if (kind != 0) begin
          repeat (inj_at) @(posedge clk);
          #1;
          case (kind)
            1: begin cpu_en = 1; cpu_wEn = 1; cpu_addr = 12'd5; cpu_dataIn = 32'hAB; end
            2: begin cpu_en = 1; cpu_wEn = 1; cpu_addr = 12'd1; cpu_dataIn = 32'hDEADBEEF; end
            3: frame_start = 1'b1;
            4: begin cpu_en = 1; cpu_wEn = 1; cpu_addr = 12'd0; cpu_dataIn = 32'd1; end
            default: begin frame_start = 1'b1; overrun_clr = 1'b1; end
          endcase
          @(posedge clk); #1;
          cpu_wEn = 1'b0; frame_start = 1'b0; overrun_clr = 1'b0;
          if (kind == 1) begin
            @(posedge clk); #1;
          end
          cpu_en = 1'b0; cpu_addr = PARK;
        end
      end
      begin
        for (int i = 0; i < 60; i++) begin
          @(negedge clk);
          cycles++;
          if (cycles == 2) check({name, "_busy"}, {63'd0, scan_busy}, 64'd1);
          if (scan_done) begin
            got = 1;
            break;
          end
        end
      end
    join
    if (!got) begin
      checks++; failures++;
      $display("FAIL %s_timeout: no scan_done within 60 cycles", name);
    end else begin
      check({name, "_length"}, 64'(cycles), 64'(exp_cycles));
    end
  endtask

  initial begin
    int seen0;
    reset = 1'b1; cpu_en = 1'b0; cpu_wEn = 1'b0; cpu_addr = PARK; cpu_dataIn = '0;
    frame_start = 1'b0; overrun_clr = 1'b0;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {snap_wr_en, snap_idx, snap_data, scan_busy, scan_done, overrun}, 64'd0);
    reset = 1'b0;

    // port mux, processor owns the port / parked
    cpu_en = 1; cpu_wEn = 1; cpu_addr = 12'h123; cpu_dataIn = 32'hCAFE;
    #1 check("mux_cpu", {19'd0, ram_wEn, ram_addr, ram_dataIn}, {19'd0, 1'b1, 12'h123, 32'hCAFE});
    cpu_en = 0;
    #1 check("mux_idle", {51'd0, ram_wEn, ram_addr}, {51'd0, 1'b0, 12'h123});
    cpu_wEn = 0; cpu_addr = PARK;

    for (int i = 1; i <= 8; i++) cpu_write(AW'(i), DW'(i * 32'h11));

    // V1 plain scan
    set_img(32'h11, 32'h55);
    run_scan("v1", 0, 0, 12);
    // V2 two-cycle stall, addr5 rewritten before it is read
    set_img(32'h11, 32'hAB);
    run_scan("v2", 2, 1, 14);
    // V3 cpu overwrites addr1 the cycle after it was read
    run_scan("v3", 2, 2, 13);
    check("v3_mem1", 64'(mem[1]), 64'hDEADBEEF);
    // V4 frame_start mid-scan together with clear, then explicit clear
    set_img(32'hDEADBEEF, 32'hAB);
    run_scan("v4a", 3, 5, 12);
    @(negedge clk);
    check("v4_overrun_set", {63'd0, overrun}, 64'd1);
    @(posedge clk); #1 overrun_clr = 1'b1;
    @(posedge clk); #1 overrun_clr = 1'b0;
    @(negedge clk);
    check("v4_overrun_clr", {63'd0, overrun}, 64'd0);
    // frame_start landing on scan_done
    run_scan("v4b", 11, 3, 12);
    @(negedge clk);
    check("v4_coincident", {62'd0, overrun, scan_busy}, 64'b10);
    repeat (4) @(negedge clk);
    check("v4_no_restart", {63'd0, scan_busy}, 64'd0);

    // V5 reset after idx 3
    seen0 = snaps_seen;
    push_img();
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (snaps_seen >= seen0 + 4) break;
    end
    check("v5_reached_idx3", 64'(snaps_seen - seen0), 64'd4);
    reset = 1'b1;
    #1;
    check("v5_reset_outputs", {snap_wr_en, snap_idx, snap_data, scan_busy, scan_done, overrun}, 64'd0);
    check("v5_reset_mux", {51'd0, ram_wEn, ram_addr}, {51'd0, 1'b0, PARK});
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (12) @(negedge clk);
    check("v5_quiet", 64'(snaps_seen - seen0), 64'd4);
    run_scan("v5b", 0, 0, 12);

    // V6 new-game flag written during a scan
    run_scan("v6", 4, 4, 13);
    check("v6_mem0", 64'(mem[0]), 64'd1);
    check("v6_never_addr0", 64'(zero_hits), 64'd0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
